joy_serial_scanner: RTL and testbench

//  Scans the external 2-player joystick shift register (parallel-load, serial-out, 24 bits).

---
 rtl/joy_serial_scanner.sv | 162 ++++++++++++++++
 tb/tb_joy_serial_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_scanner.sv
// Scans a 24-bit parallel-load/serial-out joystick register for two players and
// presents debounced active-low pads that change only on whole, repeated frames.
module joy_serial_scanner #(
    parameter int CLK_DIV  = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_JOY_DATA,
    output logic        O_JOY_CLK,
    output logic        O_JOY_LOAD,
    output logic [11:0] O_JOY1,
    output logic [11:0] O_JOY2,
    output logic        O_FRAME_STB,
    output logic        O_VALID
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_SHIFT, S_COMMIT} state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               rise;
    logic               din_s1;
    logic               din_s2;
    logic [4:0]         bit_cnt;
    logic [23:0]        frame;
    logic [23:0]        prev_frame;
    logic [3:0]         deb_cnt;
    logic [3:0]         deb_next;
    logic               load_start;
    logic               load_end;
    logic               sample_en;
    logic [11:0]        new_j1;
    logic [11:0]        new_j2;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            din_s1 <= 1'b1;
            din_s2 <= 1'b1;
        end else begin
            din_s1 <= I_JOY_DATA;
            din_s2 <= din_s1;
        end
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise = tick & ~O_JOY_CLK;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            div_cnt   <= '0;
            O_JOY_CLK <= 1'b0;
        end else if (tick) begin
            div_cnt   <= '0;
            O_JOY_CLK <= ~O_JOY_CLK;
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // S_LOAD is entered with LOAD still high; the first rise in it drops LOAD so
    // the low pulse always spans exactly one rise-to-rise period.
    always_comb begin
        state_next  = state;
        load_start  = 1'b0;
        load_end    = 1'b0;
        sample_en   = 1'b0;
        O_FRAME_STB = 1'b0;
        case (state)
            S_LOAD: begin
                if (rise) begin
                    if (O_JOY_LOAD) begin
                        load_start = 1'b1;
                    end else begin
                        load_end   = 1'b1;
                        state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (rise) begin
                    sample_en  = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (rise) begin
                    sample_en = 1'b1;
                    if (bit_cnt == 5'd23) begin
                        state_next = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                O_FRAME_STB = 1'b1;
                state_next  = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Each rise captures the bit the register presented during the period that just ended.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_JOY_LOAD <= 1'b1;
            bit_cnt    <= '0;
            frame      <= '1;
            prev_frame <= '1;
            deb_cnt    <= '0;
            O_JOY1     <= 12'hFFF;
            O_JOY2     <= 12'hFFF;
            O_VALID    <= 1'b0;
        end else begin
            if (load_start) begin
                O_JOY_LOAD <= 1'b0;
            end
            if (load_end) begin
                O_JOY_LOAD <= 1'b1;
                bit_cnt    <= '0;
            end
            if (sample_en) begin
                frame   <= {din_s2, frame[23:1]};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (O_FRAME_STB) begin
                prev_frame <= frame;
                deb_cnt    <= deb_next;
                if (deb_next >= 4'(DEBOUNCE)) begin
                    O_JOY1  <= new_j1;
                    O_JOY2  <= new_j2;
                    O_VALID <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        deb_next = 4'd1;
        if (frame == prev_frame) begin
            deb_next = (deb_cnt == 4'd15) ? 4'd15 : deb_cnt + 4'd1;
        end
    end

    // Board wiring: serial bit order versus pad bit positions.
    assign new_j1 = {frame[21], frame[20], frame[22], frame[0], frame[23], frame[1],
                     frame[2], frame[3], frame[4], frame[5], frame[6], frame[7]};
    assign new_j2 = {frame[17], frame[16], frame[18], frame[8], frame[19], frame[9],
                     frame[10], frame[11], frame[12], frame[13], frame[14], frame[15]};

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Bench for joy_serial_scanner: a behavioural shift-register board model feeds two
// instances (DEBOUNCE 2 and 1); frame-level expectations are checked at each strobe.
`timescale 1ns/1ps
module tb_joy_serial_scanner;

    localparam int CLK_DIV   = 2;
    localparam int LOAD_CYC  = 2 * CLK_DIV;
    localparam int FRAME_CYC = 26 * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        joy_data;
    logic        jclk_a, jload_a, stb_a, valid_a;
    logic        jclk_b, jload_b, stb_b, valid_b;
    logic [11:0] j1_a, j2_a, j1_b, j2_b;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    logic [23:0] plan_q[$];
    logic [24:0] exp_q_a[$];
    logic [24:0] exp_q_b[$];
    logic [23:0] hist[$];
    logic [23:0] cur_a = '1, cur_b = '1;
    logic        val_a = 1'b0, val_b = 1'b0;
    logic [24:0] last_a = {1'b0, 24'hFFFFFF};
    logic [24:0] last_b = {1'b0, 24'hFFFFFF};
    logic        pend_a = 1'b0, pend_b = 1'b0;
    logic [23:0] sr = '1;
    logic [23:0] loaded = '1;
    logic        load_prev = 1'b1, jclk_prev = 1'b0;
    logic        load_prev_t = 1'b1;
    int          last_fall = -1;

    always #5 clk = ~clk;

    assign joy_data = sr[0];

    joy_serial_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(2)) dut_a (
        .I_CLK(clk), .I_RESET(rst), .I_JOY_DATA(joy_data),
        .O_JOY_CLK(jclk_a), .O_JOY_LOAD(jload_a), .O_JOY1(j1_a), .O_JOY2(j2_a),
        .O_FRAME_STB(stb_a), .O_VALID(valid_a));

    joy_serial_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(1)) dut_b (
        .I_CLK(clk), .I_RESET(rst), .I_JOY_DATA(joy_data),
        .O_JOY_CLK(jclk_b), .O_JOY_LOAD(jload_b), .O_JOY1(j1_b), .O_JOY2(j2_b),
        .O_FRAME_STB(stb_b), .O_VALID(valid_b));

    // Pad position of each serial bit: 0..11 = J1[bit], 12..23 = J2[bit].
    function automatic logic [23:0] to_pads(input logic [23:0] f);
        int          pad_of[24];
        logic [23:0] p;
        pad_of = '{8, 6, 5, 4, 3, 2, 1, 0, 20, 18, 17, 16, 15, 14, 13, 12,
                   22, 23, 21, 19, 10, 11, 9, 7};
        p = '1;
        for (int k = 0; k < 24; k++) p[pad_of[k]] = f[k];
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Outputs follow a frame once the last DEBOUNCE captured frames are identical.
    task automatic latch_frame(input logic [23:0] f);
        hist.push_back(f);
        if (hist.size() > 2) void'(hist.pop_front());
        if (hist.size() >= 2 && hist[hist.size()-1] == hist[hist.size()-2]) begin
            cur_a = f;
            val_a = 1'b1;
        end
        cur_b = f;
        val_b = 1'b1;
        exp_q_a.push_back({val_a, to_pads(cur_a)});
        exp_q_b.push_back({val_b, to_pads(cur_b)});
    endtask

    // Shift-register board: loads while LOAD is low, shifts on JOY_CLK rises.
    always @(negedge clk) begin
        if (!jload_a) begin
            if (load_prev) begin
                loaded = (plan_q.size() != 0) ? plan_q.pop_front() : 24'hFFFFFF;
                latch_frame(loaded);
            end
            sr = loaded;
        end else if (jclk_a && !jclk_prev && load_prev) begin
            sr = {1'b1, sr[23:1]};
        end
        load_prev = jload_a;
        jclk_prev = jclk_a;
    end

    always @(negedge clk) begin
        if (pend_a) begin
            pend_a = 1'b0;
            if (exp_q_a.size() == 0) begin
                check("unexpected_stb_a", 32'(stb_a), 32'h2);
            end else begin
                last_a = exp_q_a.pop_front();
                check("pads_a", {7'd0, valid_a, j2_a, j1_a}, {7'd0, last_a});
            end
        end
        if (stb_a && !rst) begin
            check("hold_a", {7'd0, valid_a, j2_a, j1_a}, {7'd0, last_a});
            pend_a = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (pend_b) begin
            pend_b = 1'b0;
            if (exp_q_b.size() == 0) begin
                check("unexpected_stb_b", 32'(stb_b), 32'h2);
            end else begin
                last_b = exp_q_b.pop_front();
                check("pads_b", {7'd0, valid_b, j2_b, j1_b}, {7'd0, last_b});
            end
        end
        if (stb_b && !rst) begin
            check("hold_b", {7'd0, valid_b, j2_b, j1_b}, {7'd0, last_b});
            pend_b = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_fall = -1;
        end else begin
            if (!jload_a && load_prev_t) begin
                if (last_fall >= 0) check("frame_period", 32'(cyc - last_fall), 32'(FRAME_CYC));
                check("lockstep", {29'd0, jclk_b, jload_b, stb_b}, {29'd0, jclk_a, jload_a, stb_a});
                last_fall = cyc;
            end
            if (jload_a && !load_prev_t && last_fall >= 0)
                check("load_low", 32'(cyc - last_fall), 32'(LOAD_CYC));
        end
        load_prev_t = jload_a;
        cyc++;
    end

    task automatic drain(input int frames);
        int c = 0;
        int budget = (frames + 3) * FRAME_CYC;
        while ((plan_q.size() != 0 || exp_q_a.size() != 0 || exp_q_b.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("drain_in_time", 32'(c < budget), 32'h1);
    endtask

    task automatic push_frame(input logic [23:0] f, input int reps);
        for (int r = 0; r < reps; r++) plan_q.push_back(f);
    endtask

    task automatic abort_model();
        plan_q.delete();
        exp_q_a.delete();
        exp_q_b.delete();
        hist.delete();
        cur_a = '1; cur_b = '1;
        val_a = 1'b0; val_b = 1'b0;
        last_a = {1'b0, 24'hFFFFFF};
        last_b = {1'b0, 24'hFFFFFF};
        pend_a = 1'b0; pend_b = 1'b0;
    endtask

    initial begin
        logic [23:0] f;
        logic        pl;
        int          c;
        int          n;

        repeat (3) @(negedge clk);
        check("rst_pads_a", {8'd0, j2_a, j1_a}, 32'h00FF_FFFF);
        check("rst_ctrl_a", {28'd0, jclk_a, jload_a, stb_a, valid_a}, 32'h4);
        check("rst_ctrl_b", {28'd0, jclk_b, jload_b, stb_b, valid_b}, 32'h4);

        push_frame(24'hFFFFFF, 2);
        rst = 1'b0;
        drain(2);
        push_frame(~(24'h1 << 7), 2);
        drain(2);
        check("j1_bit0", {20'd0, j1_a}, 32'hFFE);
        check("j2_idle", {20'd0, j2_a}, 32'hFFF);
        check("valid_set", 32'(valid_a), 32'h1);

        for (int k = 0; k < 24; k++) begin
            push_frame(~(24'h1 << k), 2);
            drain(2);
            if (k == 17) check("walk17_j2", {8'd0, j2_a, j1_a}, 32'h007F_FFFF);
            if (k == 21) check("walk21_j1", {8'd0, j2_a, j1_a}, 32'h00FF_F7FF);
        end

        push_frame(24'hFFFFFF, 1);
        push_frame(~(24'h1 << 3), 1);
        push_frame(24'hFFFFFF, 2);
        drain(4);
        check("glitch_j1", {20'd0, j1_a}, 32'hFFF);

        for (int i = 0; i < 3; i++) begin
            push_frame(24'hA5A5A5, 1);
            push_frame(24'h5A5A5A, 1);
        end
        drain(6);

        for (int g = 0; g < 16; g++) begin
            f = 24'($urandom);
            push_frame(f, $urandom_range(1, 3));
        end
        drain(48);

        push_frame(24'h000000, 2);
        drain(2);

        c = 0;
        @(negedge clk);
        do begin
            pl = jload_a;
            @(negedge clk);
            c++;
        end while (!(jload_a && !pl) && c < 2 * FRAME_CYC);
        check("load_rise_seen", 32'(c < 2 * FRAME_CYC), 32'h1);
        repeat (11 * 2 * CLK_DIV - 1) @(negedge clk);
        rst = 1'b1;
        abort_model();
        @(negedge clk);
        check("midrst_ctrl", {29'd0, jclk_a, jload_a, valid_a}, 32'h2);
        check("midrst_pads", {8'd0, j2_a, j1_a}, 32'h00FF_FFFF);
        @(negedge clk);
        f = 24'($urandom);
        push_frame(f, 2);
        rst = 1'b0;
        drain(2);
        check("post_rst_pads", {7'd0, valid_a, j2_a, j1_a}, {7'd0, 1'b1, to_pads(f)});

        n = n_fail;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n);
        $finish;
    end

    initial begin
        #(3_000_000);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
